// File: rtl/csr_regfile_pkg.sv
// Shared CSR addresses, funct3 encodings, trap cause codes and mstatus bit positions
// for the MEM-stage CSR register file.
package csr_regfile_pkg;

    localparam logic [11:0] CSR_SSTATUS = 12'h100;
    localparam logic [11:0] CSR_STVEC   = 12'h105;
    localparam logic [11:0] CSR_SEPC    = 12'h141;
    localparam logic [11:0] CSR_SCAUSE  = 12'h142;
    localparam logic [11:0] CSR_SATP    = 12'h180;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    typedef enum logic [2:0] {
        F3_NONE = 3'd0,
        F3_RW   = 3'd1,
        F3_RS   = 3'd2,
        F3_RC   = 3'd3,
        F3_RSV  = 3'd4,
        F3_RWI  = 3'd5,
        F3_RSI  = 3'd6,
        F3_RCI  = 3'd7
    } funct3_e;

    typedef enum logic [1:0] {
        PRIV_U   = 2'd0,
        PRIV_S   = 2'd1,
        PRIV_RSV = 2'd2,
        PRIV_M   = 2'd3
    } priv_e;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_TRAP,
        ACT_MRET,
        ACT_SRET,
        ACT_WRITE
    } action_e;

    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_ECALL_U = 4'd8;
    localparam logic [3:0] CAUSE_ECALL_S = 4'd9;
    localparam logic [3:0] CAUSE_ECALL_M = 4'd11;

    localparam int unsigned MS_SIE    = 1;
    localparam int unsigned MS_MIE    = 3;
    localparam int unsigned MS_SPIE   = 5;
    localparam int unsigned MS_MPIE   = 7;
    localparam int unsigned MS_SPP    = 8;
    localparam int unsigned MS_MPP_LO = 11;
    localparam int unsigned MS_MPP_HI = 12;

    localparam logic [31:0] INST_ECALL = 32'h0000_0073;
    localparam logic [31:0] INST_UNIMP = 32'hc000_1073;

    function automatic logic [3:0] ecall_cause(input logic [1:0] priv);
        case (priv)
            PRIV_U:  return CAUSE_ECALL_U;
            PRIV_S:  return CAUSE_ECALL_S;
            default: return CAUSE_ECALL_M;
        endcase
    endfunction

endpackage

// File: rtl/csr_regfile_if.sv
// MEM-stage bundle between the pipeline and the CSR register file.
interface csr_regfile_if #(parameter int XLEN = 64);
    logic            csrfilein_valid;
    logic [31:0]     csrfilein_inst;
    logic [XLEN-1:0] csrfilein_pc;
    logic [XLEN-1:0] csrfilein_rs1;
    logic            csrfilein_csr_write;
    logic            csrfilein_is_mret;
    logic            csrfilein_is_sret;
    logic [XLEN-1:0] csrfileout_rdata;
    logic            csrfileout_redirect;
    logic [XLEN-1:0] csrfileout_redirect_pc;
    logic [1:0]      csrfileout_priv;
    logic [XLEN-1:0] csrfileout_satp;

    modport master (
        output csrfilein_valid, csrfilein_inst, csrfilein_pc, csrfilein_rs1,
               csrfilein_csr_write, csrfilein_is_mret, csrfilein_is_sret,
        input  csrfileout_rdata, csrfileout_redirect, csrfileout_redirect_pc,
               csrfileout_priv, csrfileout_satp
    );

    modport slave (
        input  csrfilein_valid, csrfilein_inst, csrfilein_pc, csrfilein_rs1,
               csrfilein_csr_write, csrfilein_is_mret, csrfilein_is_sret,
        output csrfileout_rdata, csrfileout_redirect, csrfileout_redirect_pc,
               csrfileout_priv, csrfileout_satp
    );
endinterface

// File: rtl/csr_regfile_alu.sv
// Combinational CSRRW/RS/RC (and immediate forms) new-value computation.
module csr_regfile_alu
    import csr_regfile_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] rs1,
    input  logic [4:0]      zimm,
    output logic [XLEN-1:0] new_val,
    output logic            wen
);

    logic [XLEN-1:0] src;

    always_comb begin
        src     = funct3[2] ? {{(XLEN-5){1'b0}}, zimm} : rs1;
        new_val = old_val;
        wen     = 1'b0;
        case (funct3_e'(funct3))
            F3_RW, F3_RWI: begin
                new_val = src;
                wen     = 1'b1;
            end
            // set/clear with a zero source is a pure read
            F3_RS, F3_RSI: begin
                new_val = old_val | src;
                wen     = (src != '0);
            end
            F3_RC, F3_RCI: begin
                new_val = old_val & ~src;
                wen     = (src != '0);
            end
            default: begin
                new_val = old_val;
                wen     = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/csr_regfile.sv
// Machine/supervisor CSR storage with ecall/unimp trap entry and mret/sret return;
// redirect is combinational, state commits on the following edge.
module csr_regfile
    import csr_regfile_pkg::*;
#(
    parameter int              XLEN      = 64,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic         clk,
    input  logic         rst,
    csr_regfile_if.slave bus
);

    localparam logic [XLEN-1:0] SSTATUS_MASK = {{(XLEN-9){1'b0}}, 9'h122};

    logic [XLEN-1:0] mstatus, mtvec, mepc, mcause;
    logic [XLEN-1:0] stvec, sepc, scause, satp;
    logic [1:0]      priv;

    logic [11:0]     addr;
    logic [2:0]      funct3;
    logic [4:0]      zimm;
    logic [XLEN-1:0] csr_old;
    logic [XLEN-1:0] alu_new;
    logic            alu_wen;
    logic            is_trap;
    logic            is_unimp;
    logic [XLEN-1:0] trap_cause;
    action_e         action;

    assign addr     = bus.csrfilein_inst[31:20];
    assign funct3   = bus.csrfilein_inst[14:12];
    assign zimm     = bus.csrfilein_inst[19:15];
    assign is_unimp = (bus.csrfilein_inst == INST_UNIMP);
    assign is_trap  = (bus.csrfilein_inst == INST_ECALL) || is_unimp;

    always_comb begin
        csr_old = '0;
        case (addr)
            CSR_SSTATUS: csr_old = mstatus & SSTATUS_MASK;
            CSR_STVEC:   csr_old = stvec;
            CSR_SEPC:    csr_old = sepc;
            CSR_SCAUSE:  csr_old = scause;
            CSR_SATP:    csr_old = satp;
            CSR_MSTATUS: csr_old = mstatus;
            CSR_MTVEC:   csr_old = mtvec;
            CSR_MEPC:    csr_old = mepc;
            CSR_MCAUSE:  csr_old = mcause;
            default:     csr_old = '0;
        endcase
    end

    csr_regfile_alu #(.XLEN(XLEN)) u_alu (
        .funct3  (funct3),
        .old_val (csr_old),
        .rs1     (bus.csrfilein_rs1),
        .zimm    (zimm),
        .new_val (alu_new),
        .wen     (alu_wen)
    );

    // trap > mret > sret > write; a write racing mret/sret is dropped
    always_comb begin
        action = ACT_NONE;
        if (bus.csrfilein_valid) begin
            if (is_trap)
                action = ACT_TRAP;
            else if (bus.csrfilein_is_mret)
                action = ACT_MRET;
            else if (bus.csrfilein_is_sret)
                action = ACT_SRET;
            else if (bus.csrfilein_csr_write && alu_wen)
                action = ACT_WRITE;
        end
    end

    always_comb begin
        trap_cause = is_unimp ? {{(XLEN-4){1'b0}}, CAUSE_ILLEGAL}
                              : {{(XLEN-4){1'b0}}, ecall_cause(priv)};
    end

    always_comb begin
        bus.csrfileout_redirect    = 1'b0;
        bus.csrfileout_redirect_pc = '0;
        if (!rst) begin
            case (action)
                ACT_TRAP: begin
                    bus.csrfileout_redirect    = 1'b1;
                    bus.csrfileout_redirect_pc = {mtvec[XLEN-1:2], 2'b00};
                end
                ACT_MRET: begin
                    bus.csrfileout_redirect    = 1'b1;
                    bus.csrfileout_redirect_pc = mepc;
                end
                ACT_SRET: begin
                    bus.csrfileout_redirect    = 1'b1;
                    bus.csrfileout_redirect_pc = sepc;
                end
                default: begin
                    bus.csrfileout_redirect    = 1'b0;
                    bus.csrfileout_redirect_pc = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus <= '0;
            mtvec   <= MTVEC_RST;
            mepc    <= '0;
            mcause  <= '0;
            stvec   <= '0;
            sepc    <= '0;
            scause  <= '0;
            satp    <= '0;
            priv    <= PRIV_M;
        end else begin
            case (action)
                ACT_TRAP: begin
                    mepc                          <= {bus.csrfilein_pc[XLEN-1:1], 1'b0};
                    mcause                        <= trap_cause;
                    mstatus[MS_MPIE]              <= mstatus[MS_MIE];
                    mstatus[MS_MIE]               <= 1'b0;
                    mstatus[MS_MPP_HI:MS_MPP_LO]  <= priv;
                    priv                          <= PRIV_M;
                end
                ACT_MRET: begin
                    priv                          <= mstatus[MS_MPP_HI:MS_MPP_LO];
                    mstatus[MS_MIE]               <= mstatus[MS_MPIE];
                    mstatus[MS_MPIE]              <= 1'b1;
                    mstatus[MS_MPP_HI:MS_MPP_LO]  <= PRIV_U;
                end
                ACT_SRET: begin
                    priv                          <= {1'b0, mstatus[MS_SPP]};
                    mstatus[MS_SIE]               <= mstatus[MS_SPIE];
                    mstatus[MS_SPIE]              <= 1'b1;
                    mstatus[MS_SPP]               <= 1'b0;
                end
                ACT_WRITE: begin
                    case (addr)
                        CSR_SSTATUS: mstatus <= (mstatus & ~SSTATUS_MASK) | (alu_new & SSTATUS_MASK);
                        CSR_STVEC:   stvec   <= alu_new;
                        CSR_SEPC:    sepc    <= {alu_new[XLEN-1:1], 1'b0};
                        CSR_SCAUSE:  scause  <= alu_new;
                        CSR_SATP:    satp    <= alu_new;
                        CSR_MSTATUS: mstatus <= alu_new;
                        CSR_MTVEC:   mtvec   <= alu_new;
                        CSR_MEPC:    mepc    <= {alu_new[XLEN-1:1], 1'b0};
                        CSR_MCAUSE:  mcause  <= alu_new;
                        default:     ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign bus.csrfileout_rdata = csr_old;
    assign bus.csrfileout_priv  = priv;
    assign bus.csrfileout_satp  = satp;

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: CSR RMW, trap entry, mret/sret and reset override.
module tb_csr_regfile;
    import csr_regfile_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    csr_regfile_if #(.XLEN(64)) bus ();

    csr_regfile #(.XLEN(64), .MTVEC_RST(64'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] csr_inst(input logic [11:0] a, input logic [2:0] f3, input logic [4:0] r);
        return {a, r, f3, 5'd1, 7'h73};
    endfunction

    task automatic drive(input logic v, input logic [31:0] i, input logic [63:0] p,
                         input logic [63:0] r, input logic w, input logic m, input logic s);
        bus.csrfilein_valid     = v;
        bus.csrfilein_inst      = i;
        bus.csrfilein_pc        = p;
        bus.csrfilein_rs1       = r;
        bus.csrfilein_csr_write = w;
        bus.csrfilein_is_mret   = m;
        bus.csrfilein_is_sret   = s;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // csrrs rd, csr, x0: pure read
    task automatic rd_csr(input string tag, input logic [11:0] a, input logic [63:0] exp);
        drive(1'b1, csr_inst(a, 3'd2, 5'd0), 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        check(tag, bus.csrfileout_rdata, exp);
    endtask

    initial begin
        drive(1'b0, 32'h0, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        check("rst_redirect", {63'h0, bus.csrfileout_redirect}, 64'h0);
        check("rst_redirect_pc", bus.csrfileout_redirect_pc, 64'h0);
        check("rst_priv", {62'h0, bus.csrfileout_priv}, 64'd3);
        check("rst_satp", bus.csrfileout_satp, 64'h0);
        rd_csr("rst_mstatus", CSR_MSTATUS, 64'h0);
        rd_csr("rst_mtvec", CSR_MTVEC, 64'h0);

        // csrrw mtvec
        drive(1'b1, csr_inst(CSR_MTVEC, 3'd1, 5'd1), 64'h0, 64'h8000_0100, 1'b1, 1'b0, 1'b0);
        check("mtvec_rw_old", bus.csrfileout_rdata, 64'h0);
        tick();
        rd_csr("mtvec_rw_new", CSR_MTVEC, 64'h8000_0100);

        // ecall from M
        drive(1'b1, INST_ECALL, 64'h8000_0040, 64'h0, 1'b0, 1'b0, 1'b0);
        check("ecall_redirect", {63'h0, bus.csrfileout_redirect}, 64'h1);
        check("ecall_target", bus.csrfileout_redirect_pc, 64'h8000_0100);
        tick();
        rd_csr("ecall_mepc", CSR_MEPC, 64'h8000_0040);
        rd_csr("ecall_mcause", CSR_MCAUSE, 64'd11);
        rd_csr("ecall_mstatus", CSR_MSTATUS, 64'h1800);
        check("ecall_priv", {62'h0, bus.csrfileout_priv}, 64'd3);

        // csrrs mstatus 0x8 then csrrc x0 (no write)
        drive(1'b1, csr_inst(CSR_MSTATUS, 3'd2, 5'd1), 64'h0, 64'h8, 1'b1, 1'b0, 1'b0);
        check("rs_mstatus_old", bus.csrfileout_rdata, 64'h1800);
        tick();
        rd_csr("rs_mstatus_new", CSR_MSTATUS, 64'h1808);
        drive(1'b1, csr_inst(CSR_MSTATUS, 3'd3, 5'd0), 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        tick();
        rd_csr("rc_zero_nochange", CSR_MSTATUS, 64'h1808);

        // csrrsi mtvec, 3: low bits kept, trap target still aligned
        drive(1'b1, csr_inst(CSR_MTVEC, 3'd6, 5'd3), 64'h0, 64'hdead, 1'b1, 1'b0, 1'b0);
        tick();
        rd_csr("rsi_mtvec", CSR_MTVEC, 64'h8000_0103);
        drive(1'b1, INST_ECALL, 64'h8000_0080, 64'h0, 1'b0, 1'b0, 1'b0);
        check("ecall2_target", bus.csrfileout_redirect_pc, 64'h8000_0100);
        tick();
        rd_csr("ecall2_mstatus", CSR_MSTATUS, 64'h1880);

        // mepc / mstatus setup, then mret racing a mepc write
        drive(1'b1, csr_inst(CSR_MEPC, 3'd1, 5'd1), 64'h0, 64'h8020_0001, 1'b1, 1'b0, 1'b0);
        tick();
        rd_csr("mepc_bit0", CSR_MEPC, 64'h8020_0000);
        drive(1'b1, csr_inst(CSR_MSTATUS, 3'd1, 5'd1), 64'h0, 64'h800, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, csr_inst(CSR_MEPC, 3'd1, 5'd1), 64'h0, 64'h5554, 1'b1, 1'b1, 1'b0);
        check("mret_redirect", {63'h0, bus.csrfileout_redirect}, 64'h1);
        check("mret_target", bus.csrfileout_redirect_pc, 64'h8020_0000);
        tick();
        check("mret_priv", {62'h0, bus.csrfileout_priv}, 64'd1);
        rd_csr("mret_mstatus", CSR_MSTATUS, 64'h80);
        rd_csr("mret_mepc_kept", CSR_MEPC, 64'h8020_0000);

        // sstatus masked write from S
        drive(1'b1, csr_inst(CSR_SSTATUS, 3'd1, 5'd1), 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
        check("sstatus_old", bus.csrfileout_rdata, 64'h0);
        tick();
        rd_csr("sstatus_mstatus", CSR_MSTATUS, 64'h1A2);
        rd_csr("sstatus_view", CSR_SSTATUS, 64'h122);

        // sret
        drive(1'b1, csr_inst(CSR_SEPC, 3'd1, 5'd1), 64'h0, 64'h1000, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h1020_0073, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        check("sret_target", bus.csrfileout_redirect_pc, 64'h1000);
        tick();
        check("sret_priv", {62'h0, bus.csrfileout_priv}, 64'd1);
        rd_csr("sret_mstatus", CSR_MSTATUS, 64'hA2);

        // satp and unmapped read
        drive(1'b1, csr_inst(CSR_SATP, 3'd1, 5'd1), 64'h0, 64'h8000_0000_0001_2345, 1'b1, 1'b0, 1'b0);
        tick();
        check("satp_out", bus.csrfileout_satp, 64'h8000_0000_0001_2345);
        rd_csr("unmapped_read", 12'hC00, 64'h0);

        // unimp, first suppressed then real
        drive(1'b0, INST_UNIMP, 64'h2000, 64'h0, 1'b1, 1'b0, 1'b0);
        check("unimp_inv_redirect", {63'h0, bus.csrfileout_redirect}, 64'h0);
        tick();
        rd_csr("unimp_inv_mcause", CSR_MCAUSE, 64'd11);
        rd_csr("unimp_inv_mepc", CSR_MEPC, 64'h8020_0000);
        drive(1'b1, INST_UNIMP, 64'h2000, 64'h0, 1'b1, 1'b0, 1'b0);
        check("unimp_redirect", {63'h0, bus.csrfileout_redirect}, 64'h1);
        check("unimp_target", bus.csrfileout_redirect_pc, 64'h8000_0100);
        tick();
        rd_csr("unimp_mcause", CSR_MCAUSE, 64'd2);
        rd_csr("unimp_mepc", CSR_MEPC, 64'h2000);
        rd_csr("unimp_mstatus", CSR_MSTATUS, 64'h822);
        check("unimp_priv", {62'h0, bus.csrfileout_priv}, 64'd3);

        // ecall from S: cause 9
        drive(1'b1, csr_inst(CSR_MSTATUS, 3'd1, 5'd1), 64'h0, 64'h800, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h3020_0073, 64'h0, 64'h0, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, INST_ECALL, 64'h3000, 64'h0, 1'b0, 1'b0, 1'b0);
        tick();
        rd_csr("ecall_s_mcause", CSR_MCAUSE, 64'd9);

        // reset colliding with ecall
        rst = 1'b1;
        drive(1'b1, INST_ECALL, 64'h4000, 64'h0, 1'b0, 1'b0, 1'b0);
        check("rst_ecall_redirect", {63'h0, bus.csrfileout_redirect}, 64'h0);
        tick();
        rst = 1'b0;
        rd_csr("rst2_mtvec", CSR_MTVEC, 64'h0);
        rd_csr("rst2_mepc", CSR_MEPC, 64'h0);
        rd_csr("rst2_mcause", CSR_MCAUSE, 64'h0);
        rd_csr("rst2_mstatus", CSR_MSTATUS, 64'h0);
        rd_csr("rst2_sepc", CSR_SEPC, 64'h0);
        check("rst2_priv", {62'h0, bus.csrfileout_priv}, 64'd3);
        check("rst2_satp", bus.csrfileout_satp, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine/supervisor CSR storage and trap sequencer in the MEM stage of the scpu datapath.
- Sits directly downstream of the CSR control decoder, consuming its csr_write, mem_is_mret and mem_is_sret flags together with the MEM-stage instruction, PC and rs1 operand.
- Performs CSR read/modify/write, ecall/unimp trap entry and mret/sret return.
- Produces the CSR read value for writeback and a PC redirect for fetch.

Parameters:
XLEN, 64, datapath and CSR width
MTVEC_RST, 64'h0, reset value of mtvec

Ports:
clk  input  1  core clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
csrfilein_valid  input  1  MEM-stage instruction is real (not bubble/flushed)
csrfilein_inst  input  32  MEM-stage instruction
csrfilein_pc  input  XLEN  PC of MEM-stage instruction
csrfilein_rs1  input  XLEN  rs1 operand (zero-extended zimm used for *I forms)
csrfilein_csr_write  input  1  from CSR control decoder
csrfilein_is_mret  input  1  from CSR control decoder
csrfilein_is_sret  input  1  from CSR control decoder
csrfileout_rdata  output  XLEN  old CSR value (combinational) for rd
csrfileout_redirect  output  1  fetch must jump this cycle
csrfileout_redirect_pc  output  XLEN  redirect target
csrfileout_priv  output  2  current privilege (3=M, 1=S, 0=U)
csrfileout_satp  output  XLEN  satp for MMU

Behaviour:
- Registers: mstatus, mtvec, mepc, mcause, stvec, sepc, scause, satp, priv.
- sstatus is a masked view of mstatus: bits 1 (SIE), 5 (SPIE) and 8 (SPP) only. Writes touch only those bits.
- Reset: all CSRs 0 except mtvec=MTVEC_RST; priv=3. Outputs at reset: rdata=0, redirect=0, redirect_pc=0, priv=3, satp=0.
- Read: rdata = CSR selected by inst[31:20], combinational; 0 for an unmapped address.
- Write (edge): when valid && csr_write && funct3!=0, new value is computed as follows.
  - funct3 1/5: new = src.
  - funct3 2/6: new = old|src.
  - funct3 3/7: new = old&~src.
  - src = rs1 for funct3 1–3; zero-extended inst[19:15] for funct3 5–7.
  - CSRRS/CSRRC with src==0 do not write.
- ecall (inst==32'h73, valid):
  - mepc <= pc; mcause <= 8+priv (U=8, S=9, M=11).
  - mstatus.MPIE <= MIE; MIE <= 0; MPP <= priv; priv <= 3.
  - redirect=1, redirect_pc = {mtvec[XLEN-1:2],2'b00}.
- unimp (inst==32'hc0001073, valid): same as ecall but mcause <= 2. This inst is not also treated as a CSR write.
- mret (valid && is_mret):
  - redirect_pc = mepc; priv <= MPP; MIE <= MPIE; MPIE <= 1; MPP <= 0.
- sret (valid && is_sret):
  - redirect_pc = sepc; priv <= {1'b0,SPP}; SIE <= SPIE; SPIE <= 1; SPP <= 0.
- Redirect is combinational in the same cycle the instruction is in MEM. State commits on the following edge; the next instruction sees updated CSRs.
- Priority if multiple conditions are asserted: trap > mret > sret > CSR write.
- CSR write to mepc in the same cycle as mret is ignored; the old mepc is used.
- valid=0 suppresses all updates and redirect. rdata is still driven.
- rst asserted mid-sequence overrides everything in that cycle.
- mepc/sepc writes force bit 0 to 0; mtvec/stvec writes keep all bits. Trap target ignores the low 2 bits (direct mode only).

Decomposition:
- Shared package/header (extend the existing CSR name include): CSR addresses, funct3 encodings, cause codes (2, 8, 9, 11), mstatus bit indices (SIE=1, MIE=3, SPIE=5, MPIE=7, SPP=8, MPP=12:11), privilege encodings.
- One natural sub-module: csr_alu, the combinational RW/RS/RC new-value computation.

Test Plan:
- Reset, then csrrw mtvec, rs1=64'h8000_0100, then ecall at pc=64'h8000_0040 -> next cycle mepc=64'h8000_0040, mcause=11, priv=3, redirect_pc=64'h8000_0100, MIE=0.
- csrrs mstatus with rs1=64'h8 -> rdata=old; mstatus[3]=1. Then csrrc with rs1=0 -> no change.
- Set mepc=64'h8020_0000, MPP=1 via csrrw mstatus=64'h800, then mret -> redirect_pc=64'h8020_0000, priv=1, MPP=0.
- priv=1, csrrw sstatus=64'hFFFF_FFFF_FFFF_FFFF -> mstatus changes only bits 1, 5, 8. Then sret with sepc=64'h1000 -> priv=1 (SPP=1), redirect_pc=64'h1000, SPP=0.
- unimp at pc=64'h2000 with valid=0 -> no state change, redirect=0. Same with valid=1 -> mcause=2, mepc=64'h2000.
- rst asserted in the same cycle as ecall -> all CSRs reset, priv=3, redirect=0.
